// File: rtl/mealy_pkg.sv
// Shared types and limits for the serial Mealy pattern detector.
package mealy_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HUNT = 2'd2
   } det_state_t;

   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;
   localparam int CNT_W_MIN = 1;
   localparam int CNT_W_MAX = 32;
endpackage

// File: rtl/mealy_seq_det_sat_counter.sv
// Saturating event counter: clear wins, and a sticky flag records an increment lost at all-ones.
module sat_counter
   import mealy_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   generate
      if ((CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
         $error("sat_counter: CNT_W out of range");
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (inc) begin
         if (cnt == CNT_MAX) sat <= 1'b1;
         else                cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/mealy_seq_det.sv
// Runtime-loadable serial pattern detector with a same-cycle Mealy match strobe
// and a saturating hit counter.
module mealy_seq_det
   import mealy_pkg::*;
#(
   parameter int                 PAT_W   = 4,
   parameter int                 CNT_W   = 8,
   parameter logic [PAT_W-1:0]   RST_PAT = PAT_W'(4'b1011)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             A,
   input  logic             A_vld,
   input  logic             enable,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pat,
   input  logic             cfg_overlap,
   input  logic             cnt_clr,
   output logic             k,
   output logic [CNT_W-1:0] hit_cnt,
   output logic             cnt_sat
);
   localparam int               FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   generate
      if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
         $error("mealy_seq_det: PAT_W out of range");
      end
   endgenerate

   det_state_t        state, state_n;
   logic [PAT_W-2:0]  hist, hist_n;
   logic [FILL_W-1:0] fill, fill_n;
   logic [PAT_W-1:0]  pat_r, pat_n;
   logic              ovl_r, ovl_n;
   logic              acc;
   logic [PAT_W-1:0]  window;

   assign acc    = A_vld & enable & ~cfg_we;
   assign window = {hist, A};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         hist  <= '0;
         fill  <= '0;
         pat_r <= RST_PAT;
         ovl_r <= 1'b1;
      end else begin
         state <= state_n;
         hist  <= hist_n;
         fill  <= fill_n;
         pat_r <= pat_n;
         ovl_r <= ovl_n;
      end
   end

   always_comb begin
      state_n = state;
      hist_n  = hist;
      fill_n  = fill;
      pat_n   = pat_r;
      ovl_n   = ovl_r;
      if (cfg_we) begin
         pat_n  = cfg_pat;
         ovl_n  = cfg_overlap;
         hist_n = '0;
         fill_n = '0;
      end
      if (!enable) begin
         state_n = IDLE;
         hist_n  = '0;
         fill_n  = '0;
      end else if (cfg_we) begin
         state_n = FILL;
      end else begin
         if (state == IDLE) state_n = FILL;
         if (acc) begin
            hist_n = window[PAT_W-2:0];
            if (k) begin
               // Overlap keeps the full window so the next bit can complete another match.
               if (!ovl_r) begin
                  fill_n  = '0;
                  state_n = FILL;
               end
            end else if (state != HUNT) begin
               fill_n  = fill + FILL_W'(1);
               state_n = (fill_n == FILL_MAX) ? HUNT : FILL;
            end
         end
      end
   end

   always_comb begin
      k = 1'b0;
      if ((state == HUNT) && acc && (window == pat_r)) k = 1'b1;
   end

   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (k),
      .clr (cnt_clr),
      .cnt (hit_cnt),
      .sat (cnt_sat)
   );
endmodule
